// File: rtl/eq_pkg.sv
// Shared types and constants for the slide-pot scanner.
package eq_pkg;

    // 12-bit pot value as delivered by the ADC128S.
    typedef logic [11:0] pot_t;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StStore
    } state_t;

    // Logical pot indices.
    localparam logic [2:0] IDX_LP  = 3'd0;
    localparam logic [2:0] IDX_B1  = 3'd1;
    localparam logic [2:0] IDX_B2  = 3'd2;
    localparam logic [2:0] IDX_B3  = 3'd3;
    localparam logic [2:0] IDX_HP  = 3'd4;
    localparam logic [2:0] IDX_VOL = 3'd5;

    // ADC channel wired to each logical index; entry 0 is the LP pot.
    localparam logic [5:0][2:0] CH_MAP = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

    // One step of the quarter-gain low-pass: cur + ((res - cur) >>> 2) in 13-bit signed.
    function automatic pot_t smooth(input pot_t cur, input pot_t res);
        logic signed [12:0] diff;
        logic signed [12:0] sum;
        diff = $signed({1'b0, res}) - $signed({1'b0, cur});
        sum  = $signed({1'b0, cur}) + (diff >>> 2);
        return sum[11:0];
    endfunction

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// Handshake between the pot scanner and the A2D SPI master.
interface pot_scan_ctrl_if;

    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    // Scanner side issues requests and receives results.
    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    // A2D side answers requests.
    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );

endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin slide-pot scanner: requests one A2D conversion every INTERVAL cycles,
// stores each result in a per-pot register and flags timeouts.
// Optional macro POT_SMOOTH_EN: low-pass filter each pot instead of loading raw results.
module pot_scan_ctrl
    import eq_pkg::*;
#(
    parameter int unsigned NUM_CH   = 6,
    parameter int unsigned INTERVAL = 1024,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic              clk,
    input  logic              rst,
    pot_scan_ctrl_if.master   adc,
    output pot_t [NUM_CH-1:0] pot,
    output logic              upd,
    output logic [2:0]        upd_idx,
    output logic              all_vld,
    output logic              err
);

    // One counter serves both the idle interval and the conversion timeout.
    localparam int unsigned CntMax = (INTERVAL > TIMEOUT) ? INTERVAL : TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d, idx_nxt;
    pot_t              res_q, res_d;
    logic              err_q, err_d;
    logic              store;
    pot_t              pot_wr;
    pot_t [NUM_CH-1:0] pot_q;
    logic [NUM_CH-1:0] written_q;
    logic              upd_q;
    logic [2:0]        upd_idx_q;

    assign idx_nxt = (idx_q == 3'(NUM_CH - 1)) ? 3'd0 : idx_q + 3'd1;

    // Next-state, counter, index and error logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        res_d   = res_q;
        err_d   = err_q;
        store   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cnt_q == CntW'(INTERVAL - 1)) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Completion takes priority over a timeout in the same cycle.
                if (adc.cnv_cmplt) begin
                    res_d   = adc.res;
                    cnt_d   = '0;
                    state_d = StStore;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    idx_d   = idx_nxt;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStore: begin
                store   = 1'b1;
                idx_d   = idx_nxt;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

`ifdef POT_SMOOTH_EN
    // First write after reset seeds the filter with the raw result.
    assign pot_wr = written_q[idx_q] ? smooth(pot_q[idx_q], res_q) : res_q;
`else
    assign pot_wr = res_q;
`endif

    // Pot storage, update strobe and written-once tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            pot_q     <= '0;
            written_q <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            upd_q <= store;
            if (store) begin
                pot_q[idx_q]     <= pot_wr;
                written_q[idx_q] <= 1'b1;
                upd_idx_q        <= idx_q;
            end
        end
    end

    assign adc.strt_cnv = (state_q == StStart);
    assign adc.chnnl    = CH_MAP[idx_q];
    assign pot          = pot_q;
    assign upd          = upd_q;
    assign upd_idx      = upd_idx_q;
    assign all_vld      = &written_q;
    assign err          = err_q;

endmodule
